// File: rtl/vdp_vram_arbiter.sv
// VRAM arbiter for the VDP: fixed fetch schedule in active display, sprite/CPU priority in blanking.
// Optional one-entry posted CPU write buffer when VRAM_CPU_WBUF_EN is defined.
module vdp_vram_arbiter #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 192,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [ADDR_W-1:0] bg_a,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_a,
  output logic              spr_gnt,
  output logic              spr_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] vram_a,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_q
);

  typedef enum logic [1:0] {IDLE, PEND, RDATA, ACK} cpu_state_t;

  cpu_state_t        state_reg, state_next;
  logic [2:0]        phase_q;
  logic [ADDR_W-1:0] addr_l;
  logic              we_l;
  logic [7:0]        wdata_l;
  logic              active, free, cpu_pending, spr_win, cpu_go, pend_go, accept;

`ifdef VRAM_CPU_WBUF_EN
  logic              wb_full;
  logic [ADDR_W-1:0] wb_addr;
  logic [7:0]        wb_data;
  logic              wb_load;

  // Writes go to the buffer; only reads use the PEND path, and only once the buffer is drained.
  assign cpu_pending = wb_full || (state_reg == PEND);
  assign wb_load     = !rst && (state_reg == IDLE) && cpu_req && cpu_we && !wb_full;
  assign accept      = (state_reg == IDLE) && cpu_req && !cpu_we && !wb_full;
  assign pend_go     = cpu_go && !wb_full && (state_reg == PEND);
`else
  assign cpu_pending = (state_reg == PEND);
  assign accept      = (state_reg == IDLE) && cpu_req;
  assign pend_go     = cpu_go && (state_reg == PEND);
`endif

  assign active  = (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE));
  assign free    = (phase_q == 3'd2) || (phase_q == 3'd7);
  assign spr_win = !active && spr_req && !(cpu_pending && (phase_q == 3'd7));
  assign spr_gnt = spr_win && !rst;
  assign cpu_go  = !rst && cpu_pending && (active ? free : !spr_win);
  assign cpu_ack = !rst && (state_reg == ACK);

  always_comb begin
    vram_a     = bg_a;
    vram_we    = 1'b0;
    vram_wdata = '0;
    if (rst) begin
      vram_a = '0;
    end else if (spr_gnt) begin
      vram_a = spr_a;
`ifdef VRAM_CPU_WBUF_EN
    end else if (cpu_go && wb_full) begin
      vram_a     = wb_addr;
      vram_we    = 1'b1;
      vram_wdata = wb_data;
`endif
    end else if (pend_go) begin
      vram_a     = addr_l;
      vram_we    = we_l;
      vram_wdata = we_l ? wdata_l : 8'h00;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = PEND;
`ifdef VRAM_CPU_WBUF_EN
        if (wb_load) state_next = ACK;
`endif
      end
      PEND:    if (pend_go) state_next = we_l ? ACK : RDATA;
      RDATA:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    phase_q <= pixel_x[2:0];
    if (rst) begin
      state_reg <= IDLE;
      addr_l    <= '0;
      we_l      <= 1'b0;
      wdata_l   <= 8'h00;
      cpu_rdata <= 8'h00;
      spr_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      spr_valid <= spr_gnt;
      if (accept) begin
        addr_l  <= cpu_addr;
        we_l    <= cpu_we;
        wdata_l <= cpu_wdata;
      end
      // vram_q now carries the byte addressed in the previous (slot) cycle
      if (state_reg == RDATA) cpu_rdata <= vram_q;
    end
  end

`ifdef VRAM_CPU_WBUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_full <= 1'b0;
      wb_addr <= '0;
      wb_data <= 8'h00;
    end else if (wb_load) begin
      wb_full <= 1'b1;
      wb_addr <= cpu_addr;
      wb_data <= cpu_wdata;
    end else if (cpu_go && wb_full) begin
      wb_full <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter: fetch schedule, CPU slots, blanking priority, reset abort.
module tb_vdp_vram_arbiter;
  localparam int AW = 14;
`ifdef VRAM_CPU_WBUF_EN
  localparam int ACK2 = 33;
  localparam int ACKW = 65;
  localparam int RDGO = 66;
`else
  localparam int ACK2 = 36;
  localparam int ACKW = 73;
  localparam int RDGO = 74;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    pixel_x, pixel_y;
  logic [AW-1:0] bg_a, spr_a, cpu_addr, vram_a;
  logic          spr_req, spr_gnt, spr_valid;
  logic          cpu_req, cpu_we, cpu_ack, vram_we;
  logic [7:0]    cpu_wdata, cpu_rdata, vram_wdata, vram_q;
  logic [7:0]    mem [0:16383];
  int            checks = 0;
  int            errors = 0;
  logic          ack_seen;

  always #5 clk = ~clk;

  vdp_vram_arbiter dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .bg_a(bg_a),
    .spr_req(spr_req), .spr_a(spr_a), .spr_gnt(spr_gnt), .spr_valid(spr_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .vram_a(vram_a), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_q(vram_q)
  );

  // Synchronous single-port VRAM with one-cycle read latency
  always @(posedge clk) begin
    if (rst) mem[14'h0100] <= 8'hC3;
    else if (vram_we) mem[vram_a] <= vram_wdata;
    vram_q <= mem[vram_a];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s x=%0d observed=%0h expected=%0h", tag, pixel_x, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    pixel_x = pixel_x + 10'd1;
    bg_a    = {4'b0, pixel_x} * 14'd3;
    spr_a   = 14'h2000 + {4'b0, pixel_x};
  endtask

  initial begin
    rst = 1'b1; pixel_x = 10'd0; pixel_y = 10'd10; bg_a = 14'h0155; spr_a = 14'h2000;
    spr_req = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    ack_seen = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_vram_a", vram_a, 0);
    check("rst_vram_we", vram_we, 0);
    check("rst_vram_wdata", vram_wdata, 0);
    check("rst_spr_gnt", spr_gnt, 0);
    check("rst_spr_valid", spr_valid, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);

    // Active line, bg fetch only, sprite requesting but never granted
    @(posedge clk); #1;
    rst = 1'b0; pixel_x = 10'd0; bg_a = 14'h0000; spr_a = 14'h2000;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) adv();
      #1;
      check("t1_vram_a", vram_a, i * 3);
      check("t1_vram_we", vram_we, 0);
      check("t1_spr_gnt", spr_gnt, 0);
    end

    // Active CPU write lands only in a free slot (phase 2 at x=35)
    cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 8'h5A; ack_seen = 1'b0;
    for (int x = 32; x <= 44; x++) begin
      adv();
      if (x == 32) cpu_req = 1'b1;
      else if (ack_seen) cpu_req = 1'b0;
      #1;
      check("t2_vram_we", vram_we, x == 35);
      check("t2_vram_a", vram_a, (x == 35) ? 32'h1234 : x * 3);
      if (x == 35) check("t2_vram_wdata", vram_wdata, 8'h5A);
      check("t2_cpu_ack", cpu_ack, x == ACK2);
      if (cpu_ack) ack_seen = 1'b1;
    end

    // Blanking: sprite holds VRAM, CPU read takes the phase-7 slot at x=56
    pixel_y = 10'd200;
    repeat (3) adv();
    cpu_we = 1'b0; cpu_addr = 14'h0100; ack_seen = 1'b0;
    for (int x = 48; x <= 62; x++) begin
      adv();
      if (x == 48) cpu_req = 1'b1;
      else if (ack_seen) cpu_req = 1'b0;
      #1;
      check("t3_spr_gnt", spr_gnt, x != 56);
      check("t3_vram_a", vram_a, (x == 56) ? 32'h0100 : 32'h2000 + x);
      if (x > 48) check("t3_spr_valid", spr_valid, x != 57);
      check("t3_cpu_ack", cpu_ack, x == 58);
      if (x == 58) check("t3_cpu_rdata", cpu_rdata, 8'hC3);
      if (cpu_ack) ack_seen = 1'b1;
    end

    // Write then read back 0x3FFF in blanking with sprite pressure
    adv();
    for (int x = 64; x <= 84; x++) begin
      adv();
      if (x == 64) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'hA7;
      end
      if (x == ACKW + 1) cpu_req = 1'b0;
      if (x == RDGO) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3FFF;
      end
      if (x == 83) cpu_req = 1'b0;
      #1;
      check("t4_vram_we", vram_we, x == 72);
      check("t4_spr_gnt", spr_gnt, (x != 72) && (x != 80));
      if (x == 72 || x == 80) check("t4_vram_a", vram_a, 14'h3FFF);
      if (x == 72) check("t4_vram_wdata", vram_wdata, 8'hA7);
      check("t4_cpu_ack", cpu_ack, (x == ACKW) || (x == 82));
      if (x == 82) check("t4_cpu_rdata", cpu_rdata, 8'hA7);
    end

    // Reset while a write is latched: nothing may reach VRAM afterwards
    pixel_y = 10'd10;
    adv();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0055; cpu_wdata = 8'h11;
    adv();
    rst = 1'b1;
    #1;
    check("t5_rst_vram_a", vram_a, 0);
    check("t5_rst_vram_we", vram_we, 0);
    check("t5_rst_cpu_ack", cpu_ack, 0);
    adv();
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    check("t5_spr_valid", spr_valid, 0);
    check("t5_cpu_ack", cpu_ack, 0);
    check("t5_cpu_rdata", cpu_rdata, 0);
    check("t5_spr_gnt", spr_gnt, 0);
    check("t5_vram_a", vram_a, 87 * 3);
    for (int x = 88; x <= 96; x++) begin
      adv();
      #1;
      check("t5_no_we", vram_we, 0);
      check("t5_no_ack", cpu_ack, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
